// File: rtl/tcm_pkg.sv
// ============================================================================
//  Module   : tcm_pkg
//  Purpose  : Shared encodings, widths and lane-mask helper for the TCM LSU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcm_pkg;

    localparam int DW = 32;
    localparam int MW = 4;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [MW-1:0] lane_mask(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [MW-1:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcm_rdata_align.sv
// ============================================================================
//  Module   : tcm_rdata_align
//  Purpose  : Aligns a RAM read word to the addressed lane and extends it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcm_rdata_align
    import tcm_pkg::*;
(
    input  logic [DW-1:0] ram_dout,
    input  logic [1:0]    off,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] shifted;

    always_comb begin
        shifted = ram_dout >> {off, 3'b000};
        case (size)
            SZ_B:    rdata = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SZ_H:    rdata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tcm_lsu_ctrl.sv
// ============================================================================
//  Module   : tcm_lsu_ctrl
//  Purpose  : Load/store controller driving a single-port byte-masked TCM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcm_lsu_ctrl
    import tcm_pkg::*;
#(
    parameter int DP  = 512,
    parameter int RAW = 9,
    parameter int AW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic [RAW-1:0]  ram_addr,
    output logic            ram_we,
    output logic [MW-1:0]   ram_wem,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    localparam logic [AW-3:0] DP_WORDS = (AW-2)'(DP);

    lsu_state_e     state_q,     state_d;
    logic [1:0]     off_q,       off_d;
    logic [1:0]     size_q,      size_d;
    logic           uns_q,       uns_d;
    logic           we_q,        we_d;
    logic           err_q,       err_d;
    logic [RAW-1:0] addr_hold_q, addr_hold_d;

    logic           req_fire;
    logic           rsp_fire;
    logic           req_err;
    logic [DW-1:0]  aligned;

    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        req_ready = (state_q == ST_IDLE) | rsp_ready;
        // Gating with rst_n keeps the RAM untouched while reset is asserted.
        req_fire  = req_valid & req_ready & rst_n;
        rsp_fire  = rsp_valid & rsp_ready;

        req_err = (req_size == 2'd3)
                | ((req_size == SZ_H) & req_addr[0])
                | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                | (req_addr[AW-1:2] >= DP_WORDS);

        ram_we   = req_fire & req_we & ~req_err;
        ram_wem  = ram_we ? lane_mask(req_size, req_addr[1:0]) : '0;
        ram_addr = req_fire ? req_addr[RAW+1:2] : addr_hold_q;
        case (req_size)
            SZ_B:    ram_din = {4{req_wdata[7:0]}};
            SZ_H:    ram_din = {2{req_wdata[15:0]}};
            default: ram_din = req_wdata;
        endcase

        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_hold_d = addr_hold_q;

        if (req_fire) begin
            state_d = ST_RESP;
            off_d   = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
            we_d    = req_we;
            err_d   = req_err;
            // Only good loads move the held address, so ram_dout stays put under backpressure.
            if (!req_we && !req_err) begin
                addr_hold_d = req_addr[RAW+1:2];
            end
        end else if (rsp_fire) begin
            state_d = ST_IDLE;
        end

        rsp_err   = rsp_valid & err_q;
        rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? aligned : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    tcm_rdata_align u_align (
        .ram_dout    (ram_dout),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (aligned)
    );

endmodule

`default_nettype wire

// File: tb/tb_tcm_lsu_ctrl.sv
// ============================================================================
//  Module   : tb_tcm_lsu_ctrl
//  Purpose  : Directed table-driven bench for tcm_lsu_ctrl with a TCM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcm_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcm_lsu_ctrl #(.DP(512), .RAW(9), .AW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wem      (ram_wem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // TCM model: registered address, per-lane write at the edge, preload on first edge.
    logic [31:0] mem [0:511];
    logic [8:0]  ram_addr_r = '0;
    logic        preloaded  = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[2]    <= 32'h0000_0101;
            mem[3]    <= 32'h0101_0101;
            preloaded <= 1'b1;
        end else if (ram_we) begin
            for (int l = 0; l < 4; l++)
                if (ram_wem[l]) mem[ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
        end
        ram_addr_r <= ram_addr;
    end

    assign ram_dout = mem[ram_addr_r];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_wem;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    task automatic issue(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.we, v.addr, v.size, v.uns, v.wdata);
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_ram_we", idx),  32'(ram_we),  32'(v.we & ~v.exp_err));
        chk($sformatf("v%0d_ram_wem", idx), 32'(ram_wem), 32'(v.exp_wem));
        if (v.we && !v.exp_err)
            chk($sformatf("v%0d_ram_din", idx), ram_din, v.exp_din);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_err", idx),   32'(rsp_err),   32'(v.exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        we    addr           sz  uns wdata          rdata          err   wem      din
        vt[0]  = '{1'b0, 32'h0000_0009, 2'd0, 1'b0, 32'h0,          32'h0000_0001, 1'b0, 4'b0000, 32'h0};
        vt[1]  = '{1'b1, 32'h0000_000C, 2'd0, 1'b0, 32'h1234_5680,  32'h0,         1'b0, 4'b0001, 32'h8080_8080};
        vt[2]  = '{1'b0, 32'h0000_000C, 2'd0, 1'b0, 32'h0,          32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_000C, 2'd0, 1'b1, 32'h0,          32'h0000_0080, 1'b0, 4'b0000, 32'h0};
        vt[4]  = '{1'b0, 32'h0000_000C, 2'd2, 1'b0, 32'h0,          32'h0101_0180, 1'b0, 4'b0000, 32'h0};
        vt[5]  = '{1'b0, 32'h0000_000F, 2'd0, 1'b0, 32'h0,          32'h0000_0001, 1'b0, 4'b0000, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0006, 2'd1, 1'b0, 32'hAAAA_BEEF,  32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF};
        vt[7]  = '{1'b0, 32'h0000_0006, 2'd1, 1'b0, 32'h0,          32'hFFFF_BEEF, 1'b0, 4'b0000, 32'h0};
        vt[8]  = '{1'b0, 32'h0000_0006, 2'd1, 1'b1, 32'h0,          32'h0000_BEEF, 1'b0, 4'b0000, 32'h0};
        vt[9]  = '{1'b0, 32'h0000_0006, 2'd2, 1'b0, 32'h0,          32'h0,         1'b1, 4'b0000, 32'h0};
        vt[10] = '{1'b1, 32'h0000_0005, 2'd1, 1'b0, 32'h0000_1234,  32'h0,         1'b1, 4'b0000, 32'h0};
        vt[11] = '{1'b0, 32'h0000_0008, 2'd3, 1'b0, 32'h0,          32'h0,         1'b1, 4'b0000, 32'h0};
        vt[12] = '{1'b0, 32'h0000_0800, 2'd2, 1'b0, 32'h0,          32'h0,         1'b1, 4'b0000, 32'h0};
        vt[13] = '{1'b1, 32'h0000_0800, 2'd2, 1'b0, 32'h0000_0055,  32'h0,         1'b1, 4'b0000, 32'h0};
        vt[14] = '{1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0,          32'h0,         1'b0, 4'b0000, 32'h0};
        vt[15] = '{1'b1, 32'h0000_07FC, 2'd2, 1'b0, 32'hCAFE_F00D,  32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D};
        vt[16] = '{1'b0, 32'h0000_07FC, 2'd2, 1'b0, 32'h0,          32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0};
        vt[17] = '{1'b0, 32'h0000_07FE, 2'd1, 1'b1, 32'h0,          32'h0000_CAFE, 1'b0, 4'b0000, 32'h0};
        vt[18] = '{1'b0, 32'h0000_07FD, 2'd0, 1'b0, 32'h0,          32'hFFFF_FFF0, 1'b0, 4'b0000, 32'h0};

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_rdata",     rsp_rdata,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back loads, one per cycle.
        @(negedge clk);
        drive(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        req_addr = 32'hC;
        #1;
        chk("b2b_rdata0",    rsp_rdata,      32'h0000_0101);
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("b2b_valid1", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata1", rsp_rdata,      32'h0101_0101);
        @(negedge clk);
        #1;
        chk("b2b_idle", 32'(rsp_valid), 32'd0);

        // Backpressure: three stalled cycles with a pending second request.
        drive(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_addr  = 32'hC;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("bp%0d_valid", i),     32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", i),     rsp_rdata,      32'h0000_0101);
            chk($sformatf("bp%0d_ram_addr", i),  32'(ram_addr),  32'd2);
            chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_req_ready", 32'(req_ready), 32'd1);
        chk("bp_rel_ram_addr",  32'(ram_addr),  32'd3);
        chk("bp_rel_rdata",     rsp_rdata,      32'h0000_0101);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("bp_next_rdata", rsp_rdata, 32'h0101_0101);
        @(negedge clk);

        // Store then load to the same word in consecutive cycles.
        drive(1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
        #1;
        chk("stl_ram_we",  32'(ram_we),  32'd1);
        chk("stl_ram_wem", 32'(ram_wem), 32'hF);
        @(negedge clk);
        drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        #1;
        chk("stl_st_rdata", rsp_rdata,    32'h0);
        chk("stl_st_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("stl_ld_rdata", rsp_rdata, 32'h1122_3344);

        for (int i = 0; i < 19; i++) issue(vt[i], i);

        // Asynchronous reset while a response is pending.
        @(negedge clk);
        drive(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("ar_pending", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        drive(1'b1, 32'h8, 2'd2, 1'b0, 32'h0000_DEAD);
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_rsp_err",   32'(rsp_err),   32'd0);
        chk("ar_ram_we",    32'(ram_we),    32'd0);
        chk("ar_ram_wem",   32'(ram_wem),   32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        #1;
        chk("ar_no_stale", 32'(rsp_valid), 32'd0);
        issue('{1'b0, 32'h9, 2'd0, 1'b0, 32'h0, 32'h0000_0001, 1'b0, 4'b0000, 32'h0}, 99);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcm_lsu_ctrl.md
Name: tcm_lsu_ctrl

Overview:
Initiator-side controller that drives the single-port, byte-masked TCM SRAM on behalf of the core's load/store path.
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Converts each request to a word address, lane-replicated write data and a byte write mask.
- Returns load data aligned and sign/zero-extended over a second valid/ready channel.
- Sits between the execute stage and the DTCM (or ITCM) RAM instance.

Parameters:
DP, 512, RAM depth in 32-bit words
RAW, 9, RAM word-address width (clog2(DP))
AW, 32, request byte-address width

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_addr  in  AW  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  load zero-extends when 1
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size or out-of-range
ram_addr  out  RAW  RAM word address
ram_we  out  1  RAM write enable
ram_wem  out  4  RAM byte write mask
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data

Interface contract (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- RAM contract:
  - RAM registers ram_addr on every cycle with ram_we=0.
  - ram_dout = mem[registered addr] one cycle later and holds while ram_addr is unchanged.
  - Writes commit at the clock edge, per lane of ram_wem, when ram_we=1.
- FSM states:
  - IDLE: rsp_valid=0, req_ready=1.
  - RESP: rsp_valid=1, req_ready=rsp_ready.
- Transitions:
  - IDLE -> RESP on req fire.
  - RESP -> IDLE on rsp fire without a new req fire.
  - RESP -> RESP on rsp fire together with a req fire. This gives a sustained throughput of one request per cycle.
- req fire = req_valid & req_ready. On req fire the block latches offset=req_addr[1:0], size, unsigned, we and err.
- err is set when any of these hold:
  - size==3
  - half-word with addr[0]=1
  - word with addr[1:0]!=0
  - req_addr[AW-1:2] >= DP
- ram_addr:
  - Equals req_addr[RAW+1:2] in a req-fire cycle.
  - Otherwise equals addr_hold, a register loaded with the word address of every fired load that has no error.
  - This keeps ram_dout stable under backpressure.
- ram_we = req fire & req_we & ~err. Errors never touch the RAM.
- ram_wem:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
  - forced to 0 when ram_we=0
- ram_din:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load latency: request accepted in cycle N, rsp_valid and rsp_rdata valid in cycle N+1.
  - rsp_rdata is extracted from ram_dout using the latched off/size.
  - Sign bit is 7 (byte) or 15 (half) unless unsigned.
- Store latency: write commits at the edge closing cycle N; rsp_valid in cycle N+1 with rdata=0, err=0.
- Error: rsp_valid in N+1, rsp_err=1, rdata=0, no RAM write.
- Backpressure: while rsp_valid & ~rsp_ready, rsp_valid, rsp_rdata, rsp_err and ram_addr are held stable and no new request is accepted.
- Store-then-load to the same word in consecutive cycles returns the new data; the RAM commits before the read.
- Reset (asynchronous, any time including RESP):
  - state=IDLE, rsp_valid=0, rsp_err=0, addr_hold=0, latched fields=0.
  - ram_we=0 and ram_wem=0 during reset.
  - A pending response is dropped.

Decomposition:
- Shared package tcm_pkg holds:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2
  - FSM state typedef
  - DW=32, MW=4
- One natural sub-module: tcm_rdata_align. It is purely combinational: ram_dout, off, size, unsigned -> aligned, extended 32-bit result.

Test Plan:
- DTCM preload word2=0x00000101; LB addr 0x9 -> rsp_rdata=0x00000001 in cycle N+1, err=0.
- SB 0x80 at 0xC, then LB 0xC -> 0xFFFFFF80, then LBU 0xC -> 0x00000080.
  - Word3 lanes 1..3 remain 0x01; a following LW 0xC returns 0x01010180.
- SH 0xBEEF at 0x6 -> ram_wem=4'b1100, ram_din=0xBEEFBEEF; LH 0x6 -> 0xFFFFBEEF; LHU 0x6 -> 0x0000BEEF.
- LW 0x6, SH 0x5, size=3 and LW 0x800 (DP=512) -> each gives rsp_err=1, rdata=0, ram_we never asserted.
- Back-to-back LW 0x8 and LW 0xC with rsp_ready=1 -> responses 0x00000101 and 0x01010101 on consecutive cycles.
  - With rsp_ready low 3 cycles, rdata, ram_addr and req_ready=0 are held.
- Assert rst_n low during RESP -> rsp_valid drops asynchronously. After release the first new load responds correctly with no stale response.
